// File: rtl/multirate_cic_resampler_pkg.sv
// Shared types and helpers for the multirate CIC resampler.
package multirate_cic_resampler_pkg;

  localparam int SAMPLE_W = 8;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  function automatic int w_acc(input int data_w, input int d);
    return data_w + 2 * $clog2(d) + 1;
  endfunction

  // Clamp a wide signed value into the range of a w-bit signed sample.
  function automatic logic signed [63:0] clamp(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/multirate_cic_resampler_comb_delay_line.sv
// 2D-deep circular delay line for the comb stage; taps at D and 2D.
module comb_delay_line
  import multirate_cic_resampler_pkg::*;
#(
  parameter int W = 15,
  parameter int D = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] tap_d,
  output logic [W-1:0] tap_2d
);

  localparam int N  = 2 * D;
  localparam int PW = $clog2(N);

  logic [W-1:0]  mem_q [N];
  logic [W-1:0]  mem_d [N];
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] rd_ptr;

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    if (en) begin
      mem_d[ptr_q] = din;
      ptr_d = (ptr_q == PW'(N - 1)) ? '0 : ptr_q + PW'(1);
    end
  end

  // Write slot still holds the oldest entry; half a lap back is D old.
  assign rd_ptr = (ptr_q >= PW'(D)) ? ptr_q - PW'(D) : ptr_q + PW'(D);
  assign tap_d  = mem_q[rd_ptr];
  assign tap_2d = mem_q[ptr_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N; k++) mem_q[k] <= '0;
      ptr_q <= '0;
    end else begin
      mem_q <= mem_d;
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/multirate_cic_resampler.sv
// Rational L/M resampler: zero-stuff, 2nd-order comb/integrator, decimate,
// scale and saturate, with a whole-pipeline stall when no sample is offered.
module multirate_cic_resampler
  import multirate_cic_resampler_pkg::*;
#(
  parameter int DATA_W    = SAMPLE_W,
  parameter int L         = 2,
  parameter int M         = 2,
  parameter int D         = 6,
  parameter int OUT_SHIFT = 2 * $clog2(D)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     sat_flag
);

  localparam int W_ACC = w_acc(DATA_W, D);
  localparam int PW    = (L > 1) ? $clog2(L) : 1;
  localparam int QW    = (M > 1) ? $clog2(M) : 1;

  logic [PW-1:0] p_q, p_d;
  logic [QW-1:0] q_q, q_d;
  logic [2:0]    fill_q, fill_d;

  logic signed [W_ACC-1:0] u_q, u_d;
  logic signed [W_ACC-1:0] c_q, c_d;
  logic signed [W_ACC-1:0] i1_q, i1_d;
  logic signed [W_ACC-1:0] i2_q, i2_d;

  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic out_valid_q, out_valid_d;
  logic sat_q, sat_d;

  logic adv;
  logic fill_full;
  logic signed [W_ACC-1:0] tap_d, tap_2d, s;
  logic signed [63:0] s_ext, s_clamp;

  assign in_ready  = (p_q == '0);
  assign adv       = in_valid | ~in_ready;
  assign fill_full = (fill_q == 3'd4);

  comb_delay_line #(
    .W (W_ACC),
    .D (D)
  ) u_dly (
    .clk    (clk),
    .reset  (reset),
    .en     (adv),
    .din    (u_q),
    .tap_d  (tap_d),
    .tap_2d (tap_2d)
  );

  assign s       = i2_q >>> OUT_SHIFT;
  assign s_ext   = {{(64 - W_ACC){s[W_ACC-1]}}, s};
  assign s_clamp = clamp(s_ext, DATA_W);

  always_comb begin
    p_d         = p_q;
    q_d         = q_q;
    fill_d      = fill_q;
    u_d         = u_q;
    c_d         = c_q;
    i1_d        = i1_q;
    i2_d        = i2_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    sat_d       = sat_q;
    if (adv) begin
      p_d  = (p_q == PW'(L - 1)) ? '0 : p_q + PW'(1);
      u_d  = in_ready ? {{(W_ACC - DATA_W){in_data[DATA_W-1]}}, in_data} : '0;
      c_d  = u_q - tap_d - tap_d + tap_2d;
      i1_d = i1_q + c_q;
      i2_d = i2_q + i1_q;
      if (!fill_full) begin
        fill_d = fill_q + 3'd1;
      end else begin
        // i2_q now carries a real sample; decimate on it.
        q_d = (q_q == QW'(M - 1)) ? '0 : q_q + QW'(1);
        if (q_q == '0) begin
          out_valid_d = 1'b1;
          out_data_d  = s_clamp[DATA_W-1:0];
          sat_d       = sat_q | (s_clamp != s_ext);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q         <= '0;
      q_q         <= '0;
      fill_q      <= '0;
      u_q         <= '0;
      c_q         <= '0;
      i1_q        <= '0;
      i2_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      p_q         <= p_d;
      q_q         <= q_d;
      fill_q      <= fill_d;
      u_q         <= u_d;
      c_q         <= c_d;
      i1_q        <= i1_d;
      i2_q        <= i2_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_multirate_cic_resampler.sv
// Scoreboard bench: three resampler variants checked against a
// triangular-kernel convolution model of the zero-stuffed input.
module tb_multirate_cic_resampler;

  localparam int NI = 3;
  localparam int DD = 6;
  localparam int WA = 15;

  typedef struct {
    int n;
    int y;
    bit s;
  } exp_t;

  logic clk = 1'b0;
  logic rst [NI];
  logic vld [NI];
  logic rdy [NI];
  logic ov  [NI];
  logic sat [NI];
  logic signed [7:0] din  [NI];
  logic signed [7:0] dout [NI];

  exp_t sb  [NI][$];
  int   uh  [NI][$];
  int   obs [NI][$];
  int   zl     [NI];
  int   advc   [NI];
  int   acc    [NI];
  int   last_y [NI];
  bit   msat   [NI];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multirate_cic_resampler #(
    .DATA_W(8), .L(2), .M(2), .D(DD), .OUT_SHIFT(0)
  ) u_a (
    .clk(clk), .reset(rst[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
    .in_data(din[0]), .out_valid(ov[0]), .out_data(dout[0]),
    .sat_flag(sat[0])
  );

  multirate_cic_resampler #(
    .DATA_W(8), .L(2), .M(2), .D(DD), .OUT_SHIFT(4)
  ) u_b (
    .clk(clk), .reset(rst[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
    .in_data(din[1]), .out_valid(ov[1]), .out_data(dout[1]),
    .sat_flag(sat[1])
  );

  multirate_cic_resampler #(
    .DATA_W(8), .L(1), .M(3), .D(DD), .OUT_SHIFT(4)
  ) u_c (
    .clk(clk), .reset(rst[2]), .in_valid(vld[2]), .in_ready(rdy[2]),
    .in_data(din[2]), .out_valid(ov[2]), .out_data(dout[2]),
    .sat_flag(sat[2])
  );

  function automatic int lp(input int i);
    return (i == 2) ? 1 : 2;
  endfunction

  function automatic int mp(input int i);
    return (i == 2) ? 3 : 2;
  endfunction

  function automatic int shp(input int i);
    return (i == 0) ? 0 : 4;
  endfunction

  // Impulse response of two cascaded length-D boxcars.
  function automatic int hcoef(input int k);
    return (k < DD) ? k + 1 : 2 * DD - 1 - k;
  endfunction

  function automatic void chk(input int i, input string nm,
                              input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL u%0d %s: got %0d, required %0d", i, nm, act, req);
    end
  endfunction

  function automatic void expect_at(input int i, input int n);
    longint v;
    longint m;
    exp_t e;
    v = 0;
    m = longint'(1) << WA;
    for (int k = 0; k <= 2 * DD - 2; k++)
      if (n - k >= 0) v += longint'(hcoef(k) * uh[i][n-k]);
    v = v % m;
    if (v < 0) v += m;
    if (v >= m / 2) v -= m;
    v = v >>> shp(i);
    e.n = n;
    e.s = 1'b0;
    if (v > 127) begin
      e.y = 127;
      e.s = 1'b1;
    end else if (v < -128) begin
      e.y = -128;
      e.s = 1'b1;
    end else begin
      e.y = int'(v);
    end
    sb[i].push_back(e);
  endfunction

  // Reference model: advance bookkeeping and expectation pushes.
  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < NI; i++) begin
        if (!rst[i]) begin
          if (zl[i] > 0) begin
            zl[i]--;
            advc[i]++;
          end else if (vld[i]) begin
            advc[i]++;
            for (int k = 0; k < lp(i); k++) begin
              uh[i].push_back((k == 0) ? int'(din[i]) : 0);
              if ((uh[i].size() - 1) % mp(i) == 0)
                expect_at(i, uh[i].size() - 1);
            end
            acc[i]++;
            zl[i] = lp(i) - 1;
          end
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT strobes an output.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (!rst[i]) begin
          chk(i, "in_ready", int'(rdy[i]), (zl[i] == 0) ? 1 : 0);
          if (ov[i]) begin
            if (sb[i].size() == 0) begin
              chk(i, "spurious_out_valid", 1, 0);
            end else begin
              e = sb[i].pop_front();
              chk(i, "out_data", int'(dout[i]), e.y);
              chk(i, "latency_advances", advc[i], e.n + 5);
              last_y[i] = e.y;
              msat[i] = msat[i] | e.s;
              obs[i].push_back(int'(dout[i]));
            end
          end else begin
            chk(i, "out_hold", int'(dout[i]), last_y[i]);
          end
          chk(i, "sat_flag", int'(sat[i]), int'(msat[i]));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int i);
    int g;
    g = 0;
    while (!rdy[i] && g < 16) begin
      vld[i] = 1'($urandom_range(0, 1));
      din[i] = 8'($urandom);
      cyc();
      g++;
    end
    if (!rdy[i]) chk(i, "ready_timeout", 0, 1);
  endtask

  task automatic send(input int i, input int x);
    wait_ready(i);
    vld[i] = 1'b1;
    din[i] = 8'(x);
    cyc();
  endtask

  task automatic idle(input int i, input int n);
    wait_ready(i);
    repeat (n) begin
      vld[i] = 1'b0;
      din[i] = 8'($urandom);
      cyc();
    end
  endtask

  task automatic settle(input int i);
    int n_exp;
    vld[i] = 1'b0;
    repeat (lp(i) + 1) cyc();
    n_exp = lp(i) * acc[i] - 5;
    n_exp = (n_exp < 0) ? 0 : n_exp / mp(i) + 1;
    chk(i, "out_count", obs[i].size(), n_exp);
  endtask

  task automatic do_reset(input int i);
    rst[i] = 1'b1;
    vld[i] = 1'b0;
    #1;
    chk(i, "rst_in_ready", int'(rdy[i]), 1);
    chk(i, "rst_out_valid", int'(ov[i]), 0);
    chk(i, "rst_out_data", int'(dout[i]), 0);
    chk(i, "rst_sat_flag", int'(sat[i]), 0);
    sb[i].delete();
    uh[i].delete();
    obs[i].delete();
    zl[i] = 0;
    advc[i] = 0;
    acc[i] = 0;
    last_y[i] = 0;
    msat[i] = 1'b0;
    cyc();
    rst[i] = 1'b0;
  endtask

  task automatic chk_imp(input int i, input string nm);
    int imp [6] = '{1, 3, 5, 5, 3, 1};
    chk(i, {nm, "_len"}, (obs[i].size() >= 8) ? 1 : 0, 1);
    for (int k = 0; k < 8 && k < obs[i].size(); k++)
      chk(i, nm, obs[i][k], (k < 6) ? imp[k] : 0);
  endtask

  task automatic rand_run(input int i, input int n);
    repeat (n) begin
      if ($urandom_range(0, 7) == 0) idle(i, $urandom_range(1, 4));
      send(i, int'($urandom_range(0, 255)) - 128);
    end
    settle(i);
  endtask

  task automatic drv_a();
    do_reset(0);
    send(0, 1);
    repeat (12) send(0, 0);
    settle(0);
    chk_imp(0, "impulse");

    do_reset(0);
    send(0, 1);
    send(0, 0);
    send(0, 0);
    idle(0, 5);
    repeat (10) send(0, 0);
    settle(0);
    chk_imp(0, "stall_impulse");

    do_reset(0);
    send(0, 1);
    repeat (4) send(0, 0);
    do_reset(0);
    send(0, 1);
    repeat (12) send(0, 0);
    settle(0);
    chk_imp(0, "post_reset_impulse");

    do_reset(0);
    repeat (20) send(0, -128);
    repeat (20) send(0, 0);
    settle(0);
    chk(0, "sat_sticky", int'(sat[0]), 1);
    chk(0, "sat_steady", (obs[0].size() > 10) ? obs[0][10] : 0, -128);
    chk(0, "sat_tail", int'(dout[0]), 0);

    do_reset(0);
    rand_run(0, 300);
  endtask

  task automatic drv_b();
    do_reset(1);
    repeat (30) send(1, 100);
    settle(1);
    chk(1, "dc_step",
        (obs[1].size() > 0) ? obs[1][obs[1].size()-1] : 0, 112);
    chk(1, "dc_no_sat", int'(sat[1]), 0);
    do_reset(1);
    rand_run(1, 200);
  endtask

  task automatic drv_c();
    do_reset(2);
    rand_run(2, 300);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b0;
      vld[i] = 1'b0;
      din[i] = '0;
      zl[i] = 0;
      advc[i] = 0;
      acc[i] = 0;
      last_y[i] = 0;
      msat[i] = 1'b0;
    end
    #2;
    fork
      drv_a();
      drv_b();
      drv_c();
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "bench did not complete");
  end

endmodule

// File: doc/multirate_cic_resampler.md
# multirate_cic_resampler

Parametrised rational-rate resampler: zero-stuffing interpolator by L, second-order comb/integrator (CIC-style) lowpass with differential delay D, decimator by M, plus output scaling and saturation. Successor to the fixed L=2/M=2/D=6 bandpass chain, adding a valid/ready handshake, pipeline stall, configurable rates, full-precision accumulation, and overflow reporting. Sits between the sample source and the downstream rate-converted datapath.

## Interface
- DATA_W, 8: input/output sample width, signed two's complement
- L, 2: interpolation factor, ≥1
- M, 2: decimation factor, ≥1
- D, 6: comb differential delay, ≥2
- OUT_SHIFT, 2*$clog2(D): arithmetic right shift applied before saturation
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  in_data holds a sample
- in_ready  out  1  block accepts in_data this cycle
- in_data  in  DATA_W  signed input sample
- out_valid  out  1  one-cycle strobe, out_data is a new output sample
- out_data  out  DATA_W  signed, scaled, saturated output
- sat_flag  out  1  sticky; set when any output saturated

## Operation
- W_ACC = DATA_W + 2*$clog2(D) + 1; all comb and integrator arithmetic at W_ACC, modulo 2^W_ACC (integrator wrap is intentional and harmless).
- Phase counter p, 0..L-1. in_ready = (p==0). Advance enable adv = (p!=0) | in_valid.
- On adv: u = (p==0) ? sign-extended in_data : 0; p wraps L-1 -> 0. If L=1, in_ready is constantly 1 and every advance accepts a sample.
- When adv=0 (p==0, no in_valid) the whole pipeline freezes: counters, delay line, accumulators, and out_data hold; out_valid=0.
- Comb: c[n] = u[n] - 2*u[n-D] + u[n-2D]; the delay line holds 2D entries of u.
- Integrators: i1[n] = i1[n-1] + c[n]; i2[n] = i2[n-1] + i1[n].
- Decimation counter q, 0..M-1, steps on every advance of the stage-4 result; an output is produced when q==0.
- Output: s = i2 >>> OUT_SHIFT; out_data = clamp(s, -2^(DATA_W-1), 2^(DATA_W-1)-1). Any clamp sets sat_flag, which stays set until reset.
- Fill counter saturating at 4: out_valid is suppressed until 4 advances have occurred since reset.

## Timing
- Pipeline: u_reg, c_reg, i1, i2, out register; 4 advancing cycles from acceptance to out_data.
- A sample accepted at edge t with no stalls appears at out_data/out_valid after edge t+4, provided its q==0.
- Stalls stretch latency by exactly the number of non-advancing cycles.
- Reset values: in_ready=1, out_valid=0, out_data=0, sat_flag=0, p=q=0, delay line and accumulators 0.
- Reset asserted mid-stream discards all in-flight samples immediately. The first sample after release is treated as index 0 with p=q=0.
- Simultaneous in_valid with p!=0 is ignored; in_data is not consumed.

## Structure
- Shared package: W_ACC function, saturate/clamp function, signed sample typedef.
- Sub-module comb_delay_line: 2D-deep circular buffer with read/write pointer wrap at 2D-1, enable input, taps at D and 2D.
- Top holds the counters, comb, integrators, and output stage.

## Test plan
- Impulse (L=2, M=2, D=6, OUT_SHIFT=0): in_data 1 then 0s, in_valid held high -> out_data 1,3,5,5,3,1 then 0s, each 4 cycles after its sample; in_ready toggles 1,0.
- DC step (OUT_SHIFT=4): constant 100 -> steady out_data 112 (1800>>4), sat_flag=0.
- Saturation (OUT_SHIFT=0): constant -128 -> out_data pinned at -128, sat_flag=1 and sticky after the input returns to 0.
- Stall: drop in_valid for 5 cycles at p==0 -> no out_valid, out_data held, impulse response values unchanged, latency +5.
- Reset mid-stream: assert reset during the impulse tail -> outputs 0 and in_ready=1 at once; a fresh impulse after release reproduces 1,3,5,5,3,1.
- Rates L=1, M=3: in_ready constant 1, out_valid every third advance after fill.
